regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//   Shares the single regfile write port between two writeback requesters:
//   ALU result (req 0) and load/memory unit (req 1). Round-robin arbitration,
//   valid/ready handshake, and a 1-cycle registered write stage.
//   Holds a per-register busy scoreboard, set at issue and cleared when the
//   write lands, so decode can stall on RAW hazards. Sits between execute/mem
//   stages and the regfile write port.
// PARAMETERS
//   XLEN      32  data width of register and write data
//   NUM_REGS  32  architectural registers; address width = $clog2(NUM_REGS)
// PORTS
//   clk          in   1     clock, all state updates on posedge
//   reset        in   1     synchronous, active-low reset
//   alu_valid    in   1     ALU writeback request
//   alu_ready    out  1     ALU request accepted this cycle
//   alu_rd       in   5     ALU destination register
//   alu_data     in   XLEN  ALU writeback data
//   mem_valid    in   1     load writeback request
//   mem_ready    out  1     load request accepted this cycle
//   mem_rd       in   5     load destination register
//   mem_data     in   XLEN  load writeback data
//   issue_valid  in   1     instruction issued that will write issue_rd
//   issue_rd     in   5     destination of issued instruction
//   issue_rs1    in   5     source 1 of instruction in decode
//   issue_rs2    in   5     source 2 of instruction in decode
//   busy_rs1     out  1     issue_rs1 has a write pending (combinational)
//   busy_rs2     out  1     issue_rs2 has a write pending (combinational)
//   rf_we        out  1     regfile write_enable (registered)
//   rf_rd        out  5     regfile rd (registered)
//   rf_wdata     out  XLEN  regfile rd_data (registered)
// BEHAVIOUR
//   - Reset (reset==0 at posedge): rf_we=0, rf_rd=0, rf_wdata=0, busy[*]=0,
//     priority pointer -> ALU. alu_ready=mem_ready=0 while reset==0.
//     Reset mid-operation discards the in-flight write and all busy bits.
//   - Arbitration (combinational): one grant per cycle max. Only one valid ->
//     it is granted. Both valid -> requester holding priority is granted;
//     pointer flips to the other requester after each contested grant only.
//     Uncontested grants leave pointer unchanged.
//   - Handshake: transfer when valid && ready. Requester holds valid, rd, data
//     stable until ready. ready never asserted without valid.
//   - Write stage: on transfer, next cycle rf_we=1, rf_rd/rf_wdata = granted
//     rd/data (latency 1). No transfer -> rf_we=0, rf_rd/rf_wdata hold.
//   - rd==0 transfers complete the handshake but produce rf_we=0 and never
//     touch busy state.
//   - Scoreboard busy[1..NUM_REGS-1], busy[0] hard 0:
//     set at posedge when issue_valid && issue_rd!=0;
//     cleared at posedge when rf_we==1 for rf_rd (same edge regfile updates).
//     Set and clear of same register on same edge -> set wins.
//   - busy_rsN = busy[issue_rsN]; rsN==0 -> 0. No bypass from rf_wdata:
//     value readable from regfile the cycle after rf_we.
//   - Scoreboard is not checked against requester rd; a write to a non-busy
//     register is performed normally.
// TESTING
//   1 Reset: hold reset=0 3 cycles with both valid=1 -> readies 0, rf_we 0, busy 0.
//   2 Single ALU: alu_valid, rd=5, data=0xDEADBEEF -> alu_ready same cycle;
//     next cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF; one cycle later rf_we=0.
//   3 Contention: both valid 4 cycles (rd 3/4) -> grants ALU,MEM,ALU,MEM; rf
//     writes in that order, one per cycle.
//   4 Scoreboard: issue rd=7 -> busy_rs1=1 for rs1=7; mem write rd=7 -> busy
//     clears on edge with rf_we=1; issue rd=7 on that edge keeps busy=1.
//   5 x0: alu rd=0 data=0x1 -> alu_ready=1, rf_we stays 0; issue_rd=0 ->
//     busy_rs1(rs1=0)=0.
//   6 Reset mid-op: transfer then reset=0 next edge -> rf_we=0, busy cleared.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single regfile write port: round-robin between the
// ALU and load unit, a registered write stage, and a RAW busy scoreboard.
module regfile_wb_arbiter #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic [AW-1:0]   issue_rs1,
  input  logic [AW-1:0]   issue_rs2,
  output logic            busy_rs1,
  output logic            busy_rs2,
  output logic            rf_we,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_wdata
);

  typedef enum logic {
    PRI_ALU = 1'b0,
    PRI_MEM = 1'b1
  } pri_e;

  pri_e              pri_q;
  pri_e              pri_d;
  logic              contested;
  logic              grant_alu;
  logic              grant_mem;
  logic [AW-1:0]     win_rd;
  logic [XLEN-1:0]   win_data;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;

  // The pointer only moves when both requesters competed for the port.
  always_comb begin
    contested = alu_valid && mem_valid;
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    pri_d     = pri_q;
    if (reset) begin
      if (contested) begin
        grant_alu = (pri_q == PRI_ALU);
        grant_mem = (pri_q == PRI_MEM);
        pri_d     = (pri_q == PRI_ALU) ? PRI_MEM : PRI_ALU;
      end else begin
        grant_alu = alu_valid;
        grant_mem = mem_valid;
      end
    end
    win_rd   = grant_mem ? mem_rd : alu_rd;
    win_data = grant_mem ? mem_data : alu_data;
  end

  assign alu_ready = grant_alu;
  assign mem_ready = grant_mem;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pri_q    <= PRI_ALU;
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else begin
      pri_q <= pri_d;
      rf_we <= (grant_alu || grant_mem) && (win_rd != '0);
      // x0 transfers are swallowed so the visible write port is left untouched.
      if ((grant_alu || grant_mem) && (win_rd != '0)) begin
        rf_rd    <= win_rd;
        rf_wdata <= win_data;
      end
    end
  end

  // A new issue to a register overrides a write landing on the same edge.
  always_comb begin
    busy_next = busy;
    if (rf_we) busy_next[rf_rd] = 1'b0;
    if (issue_valid && (issue_rd != '0)) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) busy <= '0;
    else        busy <= busy_next;
  end

  assign busy_rs1 = (issue_rs1 != '0) && busy[issue_rs1];
  assign busy_rs2 = (issue_rs2 != '0) && busy[issue_rs2];

endmodule
